// File: rtl/seg_scan_driver_if.sv
// Bus between the CPU-side value publisher and the 4-digit 7-segment scan driver.
// value_vld is a one-cycle strobe with no ready: the driver always accepts, last strobe in a frame wins.
interface seg_scan_driver_if;
  logic [15:0] value_in;
  logic        value_vld;
  logic [3:0]  dp_in;
  logic        blank;
  logic [3:0]  sel;
  logic [7:0]  data;
  logic        digit_tick;

  modport master (
    output value_in, value_vld, dp_in, blank,
    input  sel, data, digit_tick
  );

  modport slave (
    input  value_in, value_vld, dp_in, blank,
    output sel, data, digit_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexes a 16-bit value as 4 hex digits onto an active-low 7-segment bus.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 20
) (
  input  logic               clk,
  input  logic               rrst,
  seg_scan_driver_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pending_q, pending_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       data_q, data_d;
  logic             tc;
  logic             frame_end;
  logic             suppress;
  logic [3:0]       nibble;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tc        = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end = tc && (idx_q == 2'd3);
    cnt_d     = tc ? '0 : cnt_q + CNT_W'(1);
    idx_d     = tc ? idx_q + 2'd1 : idx_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    // A strobe on the boundary edge bypasses pending so it lands in the new frame.
    if (bus.value_vld) pending_d = bus.value_in;
    if (frame_end)     disp_d    = bus.value_vld ? bus.value_in : pending_q;

    nibble = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    suppress = (disp_q[15:12] == 4'h0);
      2'd2:    suppress = (disp_q[15:8]  == 8'h00);
      2'd1:    suppress = (disp_q[15:4]  == 12'h000);
      default: suppress = 1'b0;
    endcase
`else
    suppress = 1'b0;
`endif

    // Outputs follow the pre-edge index, so a digit switch is a single clean edge.
    sel_d  = 4'b1111;
    data_d = 8'hFF;
    if (!bus.blank && !suppress) begin
      sel_d  = ~(4'b0001 << idx_q);
      data_d = {~bus.dp_in[idx_q], seg7(nibble)};
    end
  end

  always_ff @(posedge clk) begin
    if (rrst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pending_q <= 16'h0000;
      disp_q    <= 16'h0000;
      sel_q     <= 4'b1111;
      data_q    <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.data       = data_q;
  assign bus.digit_tick = tc & ~rrst;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_DIV=4; checks sel/data/digit_tick every cycle.
// Honors SEG_LEADING_ZERO_BLANK_EN for the leading-zero frames.
module tb_seg_scan_driver;

  logic clk;
  logic rrst;
  seg_scan_driver_if bus();

  seg_scan_driver #(.SCAN_DIV(4), .CNT_W(3)) dut (
    .clk  (clk),
    .rrst (rrst),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [12:0] exp_q[$];
  int          checks;
  int          failures;
  int          k;
  int          cyc_no;
  logic [7:0]  dig[4];

  // Expected data per digit slot for the frame in progress; 8'hFF marks a dark (suppressed) slot.
  task automatic set_dig(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    dig[0] = d0;
    dig[1] = d1;
    dig[2] = d2;
    dig[3] = d3;
  endtask

  // One clock: called at a negedge with inputs already set; pushes the response seen after the edge.
  task automatic cyc();
    logic [1:0] slot;
    logic [3:0] e_sel;
    logic [7:0] e_data;
    logic       e_tick;
    if (rrst) begin
      k      = 0;
      e_tick = 1'b0;
      e_sel  = 4'b1111;
      e_data = 8'hFF;
    end else begin
      k      = k + 1;
      slot   = 2'(((k - 1) / 4) % 4);
      e_tick = ((k % 4) == 3);
      if (bus.blank || dig[slot] == 8'hFF) begin
        e_sel  = 4'b1111;
        e_data = 8'hFF;
      end else begin
        e_sel  = ~(4'b0001 << slot);
        e_data = dig[slot];
      end
    end
    exp_q.push_back({e_tick, e_sel, e_data});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic strobe(input logic [15:0] v);
    bus.value_in  = v;
    bus.value_vld = 1'b1;
    cyc();
    bus.value_vld = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [12:0] got;
    logic [12:0] exp;
    cyc_no = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() != 0) begin
        got = {bus.digit_tick, bus.sel, bus.data};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL scan_out cyc=%0d got tick=%b sel=%b data=%h exp tick=%b sel=%b data=%h",
                   cyc_no, got[12], got[11:8], got[7:0], exp[12], exp[11:8], exp[7:0]);
        end
        checks++;
        if ($countones(~bus.sel) > 1) begin
          failures++;
          $display("FAIL sel_onehot cyc=%0d got sel=%b exp at most one low bit", cyc_no, bus.sel);
        end
      end
    end
  end

  // driver
  initial begin
    checks        = 0;
    failures      = 0;
    k             = 0;
    rrst          = 1'b1;
    bus.value_in  = 16'h0000;
    bus.value_vld = 1'b0;
    bus.dp_in     = 4'b0000;
    bus.blank     = 1'b0;
    set_dig(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);

    // reset for 3 cycles, then frame 1 shows zeros; two strobes, last wins
    run(3);
    rrst = 1'b0;
    run(2);
    strobe(16'h5555);
    run(2);
    strobe(16'h1234);
    run(10);

    // frame 2 shows 1234; strobe ABCD on the boundary edge
    set_dig(8'h99, 8'hB0, 8'hA4, 8'hF9);
    run(15);
    strobe(16'hABCD);

    // frame 3 shows ABCD immediately; reload 1234
    set_dig(8'hA1, 8'hC6, 8'h83, 8'h88);
    run(7);
    strobe(16'h1234);
    run(8);

    // frame 4: decimal point on digit 1 only
    bus.dp_in = 4'b0010;
    set_dig(8'h99, 8'h30, 8'hA4, 8'hF9);
    run(16);
    bus.dp_in = 4'b0000;

    // frame 5: blank for 10 cycles mid-frame, release on the last slot
    set_dig(8'h99, 8'hB0, 8'hA4, 8'hF9);
    run(5);
    bus.blank = 1'b1;
    run(10);
    bus.blank = 1'b0;
    run(1);

    // frame 6: reset while digit 2 is mid-dwell
    run(9);
    rrst = 1'b1;
    run(1);
    rrst = 1'b0;

    // two frames of zeros (pending cleared by reset), then 0070
`ifdef SEG_LEADING_ZERO_BLANK_EN
    set_dig(8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
    set_dig(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif
    run(16);
    run(3);
    strobe(16'h0070);
    run(12);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    set_dig(8'hC0, 8'hF8, 8'hFF, 8'hFF);
`else
    set_dig(8'hC0, 8'hF8, 8'hC0, 8'hC0);
`endif
    run(16);

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage of cpu_top. Consumes a 16-bit value published by the CPU datapath, such as a register or memory word selected via swi. Time-multiplexes that value as 4 hex digits onto the shared 4-digit 7-segment bus (sel/data). It holds a pending value and swaps it in only at frame boundaries, so the display never shows a torn value.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit; legal range 2..2^20; bench uses 4.
CNT_W, 20, width of the dwell counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rrst  input  1  reset; one clock, synchronous, active-high.
value_in  input  16  value from the CPU; digit0 = [3:0], digit3 = [15:12].
value_vld  input  1  1-cycle strobe; captures value_in into the pending register.
dp_in  input  4  decimal point per digit; 1 = lit, sampled live.
blank  input  1  1 = all digits dark; scanning continues.
sel  output  4  digit enables, active-low, one-hot-zero; bit i = digit i.
data  output  8  segments, active-low; [7]=dp, [6:0]=g..a.
digit_tick  output  1  1-cycle pulse on each digit advance.

Behaviour:
- Reset (rrst=1 at a clock edge):
  - sel=4'b1111, data=8'hFF, digit_tick=0.
  - Dwell counter=0, digit index=0, pending=16'h0000, displayed=16'h0000.
  - Reset mid-frame aborts the scan immediately. There is no partial-state carry-over.
- Dwell counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Terminal count (cnt==SCAN_DIV-1) raises digit_tick combinationally in that cycle.
  - On the same edge, digit index advances 0→1→2→3→0.
- Frame boundary = terminal count while index==3.
  - At that edge, displayed <= (value_vld ? value_in : pending). This bypass means a strobe coinciding with the boundary lands in the new frame.
- value_vld outside a boundary:
  - pending <= value_in; displayed is unchanged until the next boundary.
  - Multiple strobes per frame: last one wins.
- Outputs are registered with 1-cycle latency from the index and displayed value.
  - First edge with rrst=0 → sel=4'b1110, data=seg(displayed[3:0]).
  - Each digit is lit for exactly SCAN_DIV cycles; the sel sequence is 1110, 1101, 1011, 0111.
- Segment code for data[6:0] = g..a, active-low:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10
  - A:08 b:03 C:46 d:21 E:06 F:0E
  - data[7] = ~dp_in[index]. For example, with dp off, digit 0 → 8'hC0.
- blank=1 at an edge → next cycle sel=4'b1111, data=8'hFF. The counter, index, pending and digit_tick are unaffected. On release, the current digit shows the next cycle.
- No output ever has two sel bits low; a change of index is a clean single-edge switch.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN
- Defined: digit i (i=3..1) is suppressed when displayed nibbles i..3 are all zero. While suppressed, sel bit stays 1 and data=8'hFF for that dwell slot; timing and digit_tick are unchanged. Digit 0 is always shown. dp_in does not override suppression.
- Undefined: all four digits are always shown.

Test Plan:
1. Reset: rrst=1 for 3 cycles, then 0.
   → sel=1111/data=FF during reset.
   → First edge after release: sel=1110, data=C0.
   → digit_tick every 4th cycle (SCAN_DIV=4).
2. value_vld pulse with value_in=16'h1234 while index=1.
   → Rest of frame still shows 0 (C0).
   → Next frame: 1110/99, 1101/B0, 1011/A4, 0111/F9, 4 cycles each.
3. Strobe exactly at the frame-boundary cycle with 16'hABCD.
   → New frame digit0 data=A1 (d), digit3 data=88 (A). No frame of stale value.
4. dp_in=4'b0010, displayed=16'h1234 → digit1 data=8'h30; other digits keep bit7=1.
5. blank=1 for 10 cycles mid-frame.
   → sel=1111, data=FF from the next cycle; digit_tick continues every 4 cycles.
   → On release, the digit shown matches the index the counter has reached.
6. Reset at index 2 mid-dwell → next cycle sel=1111/FF, displayed=0, scan restarts at digit 0.
   - With SEG_LEADING_ZERO_BLANK_EN and value 16'h0070: digits 3 and 2 dark (sel bit 1, FF); digit1=F8, digit0=C0.
   - Without the macro: digit3=C0.
